key_select_sequencer: RTL and testbench

Upstream stage for the 4-to-1 multiplexor exercise. It turns the two raw active-low DE0-CV push-buttons into a clean, registered select value that drives the mux "sel" input. Each key is synchronised and debounced. One key steps the select up and the other steps it down, both with wrap-around. Pressing both keys together clears the select to zero.

---
 rtl/key_select_sequencer.sv | 112 +++++++++++
 tb/tb_key_select_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/key_select_sequencer.sv
// Push-button front end for the 4-to-1 mux: synchronises and debounces two
// active-low keys, then steps a registered select up/down or clears it.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1, r_s2;
  logic             r_level, r_level_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_key;
      r_s2      <= r_s1;
      r_level_q <= r_level;
      // Counter only runs while s2 disagrees; it clears on commit, so it never wraps.
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level_q & ~r_level;
endmodule

module key_select_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SEL_WIDTH       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              key,
  output logic [SEL_WIDTH-1:0]    sel,
  output logic [2**SEL_WIDTH-1:0] sel_onehot,
  output logic                    sel_changed,
  output logic [1:0]              key_pressed
);
  localparam int NUM_KEYS = 2;
  localparam int NUM_SEL  = 2**SEL_WIDTH;

  logic [NUM_KEYS-1:0]  w_level;
  logic [NUM_KEYS-1:0]  w_press;
  logic [SEL_WIDTH-1:0] w_sel_nxt;
  logic [NUM_SEL-1:0]   w_onehot_nxt;
  logic                 w_upd;

  logic [SEL_WIDTH-1:0] r_sel;
  logic [NUM_SEL-1:0]   r_onehot;
  logic                 r_changed;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_KEYS-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key   (key),
    .o_level (w_level),
    .o_press (w_press)
  );

  // key[0] steps up, key[1] steps down, both together clear.
  always_comb begin
    w_sel_nxt    = r_sel;
    w_onehot_nxt = '0;
    w_upd        = |w_press;
    case (w_press)
      2'b01:   w_sel_nxt = r_sel + SEL_WIDTH'(1);
      2'b10:   w_sel_nxt = r_sel - SEL_WIDTH'(1);
      2'b11:   w_sel_nxt = '0;
      default: w_sel_nxt = r_sel;
    endcase
    w_onehot_nxt[w_sel_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_onehot  <= NUM_SEL'(1);
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_upd;
      if (w_upd) begin
        r_sel    <= w_sel_nxt;
        r_onehot <= w_onehot_nxt;
      end
    end
  end

  assign sel         = r_sel;
  assign sel_onehot  = r_onehot;
  assign sel_changed = r_changed;
  assign key_pressed = ~w_level;
endmodule

// File: tb/tb_key_select_sequencer.sv
// Directed bench for key_select_sequencer with a short debounce window (4 cycles).

module tb_key_select_sequencer;
  localparam int DB = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] key;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic       sel_changed;
  logic [1:0] key_pressed;

  int n_chk = 0;
  int n_err = 0;

  key_select_sequencer #(.DEBOUNCE_CYCLES(DB), .SEL_WIDTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .sel         (sel),
    .sel_onehot  (sel_onehot),
    .sel_changed (sel_changed),
    .key_pressed (key_pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press keys in 'mask' (1 = pressed), hold, release; expect sel = exp on edge DB+3.
  task automatic press(input logic [1:0] mask, input logic [1:0] exp);
    logic [3:0] oh;
    oh  = 4'b0001 << exp;
    key = ~mask;
    repeat (DB + 1) step();
    chk("kp_before", key_pressed, 2'b00);
    step();
    chk("kp_after", key_pressed, mask);
    chk("chg_early", sel_changed, 1'b0);
    step();
    chk("sel", sel, exp);
    chk("onehot", sel_onehot, oh);
    chk("chg_pulse", sel_changed, 1'b1);
    step();
    chk("chg_end", sel_changed, 1'b0);
    repeat (3) step();
    chk("hold_sel", sel, exp);
    chk("hold_chg", sel_changed, 1'b0);
    key = 2'b11;
    repeat (DB + 1) step();
    chk("kp_rel_before", key_pressed, mask);
    step();
    chk("kp_rel_after", key_pressed, 2'b00);
    repeat (2) step();
    chk("rel_sel", sel, exp);
    chk("rel_chg", sel_changed, 1'b0);
  endtask

  initial begin
    logic saw_chg, saw_kp;
    rst_n = 1'b0;
    key   = 2'b11;
    repeat (3) step();
    chk("rst_sel", sel, 2'd0);
    chk("rst_onehot", sel_onehot, 4'b0001);
    chk("rst_chg", sel_changed, 1'b0);
    chk("rst_kp", key_pressed, 2'b00);
    rst_n = 1'b1;
    repeat (2) step();

    // up steps with wrap, then down wrap
    press(2'b01, 2'd1);
    press(2'b01, 2'd2);
    press(2'b01, 2'd3);
    press(2'b01, 2'd0);
    press(2'b10, 2'd3);

    // bounce: 3 low, 1 high, five times
    saw_chg = 1'b0;
    saw_kp  = 1'b0;
    for (int r = 0; r < 5; r++) begin
      key = 2'b10;
      for (int c = 0; c < 3; c++) begin
        step();
        saw_chg |= sel_changed;
        saw_kp  |= key_pressed[0];
      end
      key = 2'b11;
      step();
      saw_chg |= sel_changed;
      saw_kp  |= key_pressed[0];
    end
    repeat (6) begin
      step();
      saw_chg |= sel_changed;
      saw_kp  |= key_pressed[0];
    end
    chk("bounce_chg", saw_chg, 1'b0);
    chk("bounce_kp", saw_kp, 1'b0);
    chk("bounce_sel", sel, 2'd3);

    // simultaneous press from 2, then again from 0
    press(2'b10, 2'd2);
    press(2'b11, 2'd0);
    press(2'b11, 2'd0);

    // release and re-press key[1]
    press(2'b10, 2'd3);
    press(2'b10, 2'd2);

    // async reset in the middle of a debounce count, key held through release
    key = 2'b10;
    repeat (3) step();
    rst_n = 1'b0;
    #2;
    chk("arst_sel", sel, 2'd0);
    chk("arst_onehot", sel_onehot, 4'b0001);
    chk("arst_chg", sel_changed, 1'b0);
    chk("arst_kp", key_pressed, 2'b00);
    step();
    rst_n = 1'b1;
    press(2'b01, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
